// File: rtl/axi_node_pkg.sv
// Shared types and helpers for the AXI node request path.
// Defaults here size the W demultiplexer and its selection FIFO.
package axi_node_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int N_OUT_DEF      = 4;
  localparam int SEL_WIDTH_DEF  = $clog2(N_OUT_DEF) + 1;
  localparam int FIFO_DEPTH_DEF = 4;

  // Destination index; the extra top bit lets it name the error sink.
  typedef logic [SEL_WIDTH_DEF-1:0] sel_t;

  // First index past the real ports: selects the decode-error sink.
  localparam sel_t ERR_SEL = sel_t'(N_OUT_DEF);

  // Width of a 0..depth occupancy counter.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axi_w_demux_if.sv
// W-channel demux bundle: AW selection input, upstream W beat, N_OUT downstream W ports.
// master = the side issuing selections/beats and driving downstream ready; slave = the demux.
interface axi_w_demux_if #(
  parameter int DATA_WIDTH = axi_node_pkg::DATA_WIDTH_DEF,
  parameter int N_OUT      = axi_node_pkg::N_OUT_DEF,
  parameter int SEL_WIDTH  = axi_node_pkg::SEL_WIDTH_DEF,
  parameter int FIFO_DEPTH = axi_node_pkg::FIFO_DEPTH_DEF
);
  import axi_node_pkg::*;

  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload is held while valid && !ready.
  logic                        AW_SEL_VALID;
  logic                        AW_SEL_READY;
  logic [SEL_WIDTH-1:0]        AW_SEL;
  logic                        W_IN_VALID;
  logic                        W_IN_READY;
  logic [DATA_WIDTH-1:0]       W_IN_DATA;
  logic                        W_IN_LAST;
  logic [N_OUT-1:0]            W_OUT_VALID;
  logic [N_OUT-1:0]            W_OUT_READY;
  logic [N_OUT*DATA_WIDTH-1:0] W_OUT_DATA;
  logic [N_OUT-1:0]            W_OUT_LAST;
  logic                        W_DROP;
  logic [CNT_W-1:0]            OUTSTANDING;

  modport master (
    output AW_SEL_VALID, AW_SEL, W_IN_VALID, W_IN_DATA, W_IN_LAST, W_OUT_READY,
    input  AW_SEL_READY, W_IN_READY, W_OUT_VALID, W_OUT_DATA, W_OUT_LAST,
           W_DROP, OUTSTANDING
  );

  modport slave (
    input  AW_SEL_VALID, AW_SEL, W_IN_VALID, W_IN_DATA, W_IN_LAST, W_OUT_READY,
    output AW_SEL_READY, W_IN_READY, W_OUT_VALID, W_OUT_DATA, W_OUT_LAST,
           W_DROP, OUTSTANDING
  );

endinterface

// File: rtl/axi_sel_fifo.sv
// In-order synchronous FIFO of routing selections, no fall-through.
// Head is read straight from the storage flops; all outputs are quiet during reset.
module axi_sel_fifo #(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 4,
  localparam int CNT_W = axi_node_pkg::cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Full is taken from the registered count only, so a pop in the same
  // cycle never frees a slot for a push.
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign push_ready = !full && !rst;
  assign head_valid = !empty && !rst;
  assign head       = mem_q[rd_ptr_q];
  assign count      = rst ? '0 : count_q;
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && head_valid;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset: clearing the count already discards every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/axi_w_demux.sv
// Routes the upstream W channel to one of N_OUT ports, burst by burst, using
// selections queued at AW time; out-of-range selections drain into a sink.
module axi_w_demux #(
  parameter int DATA_WIDTH = axi_node_pkg::DATA_WIDTH_DEF,
  parameter int N_OUT      = axi_node_pkg::N_OUT_DEF,
  parameter int SEL_WIDTH  = axi_node_pkg::SEL_WIDTH_DEF,
  parameter int FIFO_DEPTH = axi_node_pkg::FIFO_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  axi_w_demux_if.slave  bus
);
  import axi_node_pkg::*;

  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  logic                 sel_ready;
  logic                 head_valid;
  logic [SEL_WIDTH-1:0] head_sel;
  logic [CNT_W-1:0]     outstanding;
  logic                 route;
  logic                 sink;
  logic                 in_ready;
  logic                 pop;
  logic [N_OUT-1:0]     out_valid;
  logic [N_OUT-1:0]     out_last;

  axi_sel_fifo #(
    .WIDTH (SEL_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_sel_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus.AW_SEL_VALID),
    .push_ready (sel_ready),
    .push_data  (bus.AW_SEL),
    .pop        (pop),
    .head_valid (head_valid),
    .head       (head_sel),
    .count      (outstanding)
  );

  assign route = head_valid && (head_sel < SEL_WIDTH'(N_OUT));
  assign sink  = head_valid && !route;

  // The head only moves on a last-beat handshake, so a stalled port keeps
  // seeing the same valid until its ready rises.
  always_comb begin
    out_valid = '0;
    out_last  = '0;
    in_ready  = sink;
    for (int i = 0; i < N_OUT; i++) begin
      if (route && (head_sel == SEL_WIDTH'(i))) begin
        out_valid[i] = bus.W_IN_VALID;
        out_last[i]  = bus.W_IN_LAST;
        in_ready     = bus.W_OUT_READY[i];
      end
    end
  end

  assign pop = bus.W_IN_VALID && in_ready && bus.W_IN_LAST;

  assign bus.AW_SEL_READY = sel_ready;
  assign bus.W_IN_READY   = in_ready;
  assign bus.W_OUT_VALID  = out_valid;
  assign bus.W_OUT_LAST   = out_last;
  assign bus.W_OUT_DATA   = {N_OUT{bus.W_IN_DATA}};
  assign bus.W_DROP       = sink && bus.W_IN_VALID;
  assign bus.OUTSTANDING  = outstanding;

endmodule

// File: tb/tb_axi_w_demux.sv
// Randomized bench for axi_w_demux: a per-cycle reference model of the selection
// queue plus a beat scoreboard fed by the W driver.
module tb_axi_w_demux;
  import axi_node_pkg::*;

  localparam int DW = 64;
  localparam int NO = 4;
  localparam int SW = 3;
  localparam int FD = 4;
  localparam int EW = SW + 1 + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  axi_w_demux_if #(.DATA_WIDTH(DW), .N_OUT(NO), .SEL_WIDTH(SW), .FIFO_DEPTH(FD)) bus ();

  axi_w_demux #(.DATA_WIDTH(DW), .N_OUT(NO), .SEL_WIDTH(SW), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int drop_seen = 0;

  logic [EW-1:0] exp_q[$];
  logic [SW-1:0] aw_issued[$];
  int            burst_idx = 0;
  bit            rdy_rand = 1'b0;
  logic [NO-1:0] rdy_force = '1;
  int            gap_max = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic sb_beat(input int port, input bit is_drop);
    logic [EW-1:0] e;
    int dest;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_unexpected: beat on port %0d got, expected none at %0t", port, $time);
      return;
    end
    e = exp_q.pop_front();
    dest = int'(e[EW-1 -: SW]);
    if (is_drop) begin
      chk("sb_drop_dest", 64'(dest >= NO), 64'd1);
      chk("sb_drop_data", bus.W_OUT_DATA[DW-1:0], e[DW-1:0]);
    end else begin
      chk("sb_dest", 64'(port), 64'(dest));
      chk("sb_last", 64'(bus.W_OUT_LAST[port]), 64'(e[DW]));
      chk("sb_data", bus.W_OUT_DATA[port*DW +: DW], e[DW-1:0]);
    end
  endtask

  // Downstream ready driver.
  initial begin
    bus.W_OUT_READY = '1;
    forever begin
      @(posedge clk); #1;
      bus.W_OUT_READY = rdy_rand ? NO'($urandom) : rdy_force;
    end
  end

  // Reference model: pending selections as a plain queue, outputs from the routing rules.
  initial begin : monitor
    logic [SW-1:0] sel_m[$];
    logic [NO-1:0] e_val, e_last;
    logic          e_in_rdy, e_drop, e_aw_rdy, hv;
    int            cnt, hi;
    forever begin
      @(negedge clk);
      cnt      = sel_m.size();
      e_aw_rdy = !rst && (cnt < FD);
      hv       = !rst && (cnt > 0);
      hi       = hv ? int'(sel_m[0]) : 0;
      e_val    = '0;
      e_last   = '0;
      e_in_rdy = 1'b0;
      e_drop   = 1'b0;
      if (hv && hi < NO) begin
        e_val[hi]  = bus.W_IN_VALID;
        e_last[hi] = bus.W_IN_LAST;
        e_in_rdy   = bus.W_OUT_READY[hi];
      end else if (hv) begin
        e_in_rdy = 1'b1;
        e_drop   = bus.W_IN_VALID;
      end
      chk("aw_sel_ready", 64'(bus.AW_SEL_READY), 64'(e_aw_rdy));
      chk("outstanding", 64'(bus.OUTSTANDING), rst ? 64'd0 : 64'(cnt));
      chk("w_in_ready", 64'(bus.W_IN_READY), 64'(e_in_rdy));
      chk("w_out_valid", 64'(bus.W_OUT_VALID), 64'(e_val));
      chk("w_out_last", 64'(bus.W_OUT_LAST), 64'(e_last));
      chk("w_drop", 64'(bus.W_DROP), 64'(e_drop));
      for (int p = 0; p < NO; p++)
        chk("w_out_data", bus.W_OUT_DATA[p*DW +: DW], bus.W_IN_DATA);
      for (int p = 0; p < NO; p++)
        if (bus.W_OUT_VALID[p] && bus.W_OUT_READY[p]) sb_beat(p, 1'b0);
      if (bus.W_DROP) begin
        drop_seen++;
        sb_beat(NO, 1'b1);
      end
      if (rst) sel_m.delete();
      else begin
        if (bus.W_IN_VALID && e_in_rdy && bus.W_IN_LAST) void'(sel_m.pop_front());
        if (bus.AW_SEL_VALID && e_aw_rdy) sel_m.push_back(bus.AW_SEL);
      end
    end
  end

  task automatic aw_push(input logic [SW-1:0] sel);
    int waited = 0;
    bit ok = 1'b0;
    bus.AW_SEL_VALID = 1'b1;
    bus.AW_SEL       = sel;
    while (!ok) begin
      @(negedge clk); ok = bus.AW_SEL_READY;
      @(posedge clk); #1;
      if (!ok) begin
        waited++;
        if (waited > 300) begin
          n_checks++;
          $display("FAIL aw_timeout: AW_SEL_READY got 0, expected 1 within 300 cycles");
          break;
        end
      end
    end
    bus.AW_SEL_VALID = 1'b0;
    if (ok) aw_issued.push_back(sel);
  endtask

  task automatic send_beat(input logic [SW-1:0] dest, input logic last);
    logic [DW-1:0] d;
    int waited = 0;
    bit ok = 1'b0;
    d = {$urandom, $urandom};
    exp_q.push_back({dest, last, d});
    bus.W_IN_VALID = 1'b1;
    bus.W_IN_DATA  = d;
    bus.W_IN_LAST  = last;
    while (!ok) begin
      @(negedge clk); ok = bus.W_IN_READY;
      @(posedge clk); #1;
      if (!ok) begin
        waited++;
        if (waited > 300) begin
          n_checks++;
          $display("FAIL w_timeout: W_IN_READY got 0, expected 1 within 300 cycles");
          void'(exp_q.pop_back());
          break;
        end
      end
    end
    bus.W_IN_VALID = 1'b0;
    bus.W_IN_LAST  = 1'b0;
  endtask

  task automatic send_burst(input int n);
    int waited = 0;
    logic [SW-1:0] dest;
    while (aw_issued.size() <= burst_idx) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 500) begin
        n_checks++;
        $display("FAIL burst_timeout: selection count got %0d, expected > %0d", aw_issued.size(), burst_idx);
        return;
      end
    end
    dest = aw_issued[burst_idx];
    burst_idx++;
    for (int b = 0; b < n; b++) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
      send_beat(dest, b == n - 1);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
    aw_issued.delete();
    exp_q.delete();
    burst_idx = 0;
  endtask

  initial begin #500000; $display("FAIL watchdog: run got stuck, expected completion"); $fatal(1); end

  initial begin
    int d0;
    bus.AW_SEL_VALID = 1'b0;
    bus.AW_SEL       = '0;
    bus.W_IN_VALID   = 1'b1;
    bus.W_IN_DATA    = {$urandom, $urandom};
    bus.W_IN_LAST    = 1'b0;

    // Reset with upstream W pending.
    repeat (3) begin
      @(negedge clk);
      chk("rst_w_in_ready", 64'(bus.W_IN_READY), 64'd0);
      chk("rst_w_out_valid", 64'(bus.W_OUT_VALID), 64'd0);
      chk("rst_aw_ready", 64'(bus.AW_SEL_READY), 64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus.W_IN_VALID = 1'b0;
    @(negedge clk);
    chk("release_aw_ready", 64'(bus.AW_SEL_READY), 64'd1);
    @(posedge clk); #1;

    // Basic routing to port 2.
    aw_push(3'd2);
    @(negedge clk);
    chk("basic_outstanding1", 64'(bus.OUTSTANDING), 64'd1);
    @(posedge clk); #1;
    send_burst(4);
    @(negedge clk);
    chk("basic_outstanding0", 64'(bus.OUTSTANDING), 64'd0);
    @(posedge clk); #1;

    // Ordering with port 1 stalled mid-burst.
    aw_push(3'd1);
    aw_push(3'd3);
    fork
      begin send_burst(4); send_burst(2); end
      begin
        repeat (2) begin @(posedge clk); #1; end
        rdy_force = 4'b1101;
        repeat (5) begin @(posedge clk); #1; end
        rdy_force = '1;
      end
    join

    // Full selection FIFO; fifth push waits for the first pop.
    for (int i = 0; i < FD; i++) aw_push(SW'(i));
    @(negedge clk);
    chk("full_aw_ready", 64'(bus.AW_SEL_READY), 64'd0);
    chk("full_outstanding", 64'(bus.OUTSTANDING), 64'd4);
    @(posedge clk); #1;
    fork
      aw_push(3'd2);
      begin repeat (3) begin @(posedge clk); #1; end send_burst(1); end
    join
    send_burst(2);
    send_burst(1);
    send_burst(3);
    send_burst(2);

    // Decode-error sink.
    d0 = drop_seen;
    aw_push(ERR_SEL);
    send_burst(3);
    @(negedge clk);
    chk("drop_count", 64'(drop_seen - d0), 64'd3);
    chk("drop_outstanding", 64'(bus.OUTSTANDING), 64'd0);
    @(posedge clk); #1;

    // Reset in the middle of a burst.
    aw_push(3'd1);
    aw_push(3'd2);
    send_beat(3'd1, 1'b0);
    send_beat(3'd1, 1'b0);
    do_reset(2);
    @(negedge clk);
    chk("midrst_outstanding", 64'(bus.OUTSTANDING), 64'd0);
    @(posedge clk); #1;
    aw_push(3'd0);
    send_burst(2);

    // Randomized traffic with random readies and gaps.
    rdy_rand = 1'b1;
    gap_max  = 2;
    fork
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
        aw_push(sel_t'($urandom_range(7, 0)));
      end
      for (int k = 0; k < 40; k++) send_burst($urandom_range(4, 1));
    join
    rdy_rand = 1'b0;
    gap_max  = 0;

    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("end_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("end_outstanding", 64'(bus.OUTSTANDING), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
